// File: rtl/storage_read_ctrl.sv
// Read-side controller for small registered storage blocks: request handshake, one-cycle read
// strobe, data capture and a held response. Define STORAGE_RD_PARITY_EN to add even parity.
module storage_read_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic              rsp_err,
    output logic              rsp_parity
);

    typedef enum logic [1:0] {StIdle, StIssue, StCapture, StHold} state_e;

    // One extra bit so DEPTH == 2^ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] DepthLim = (ADDR_W + 1)'(DEPTH);

    state_e              state_q, state_d;
    logic                req_ready_q, req_ready_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]   mem_rd_addr_q, mem_rd_addr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [ADDR_W-1:0]   rsp_addr_q, rsp_addr_d;
    logic                rsp_err_q, rsp_err_d;
    logic                in_range;

    assign in_range = ({1'b0, req_addr} < DepthLim);

`ifdef STORAGE_RD_PARITY_EN
    logic rsp_parity_q, rsp_parity_d;
`endif

    always_comb begin
        state_d       = state_q;
        mem_rd_en_d   = 1'b0;
        mem_rd_addr_d = mem_rd_addr_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_addr_d    = rsp_addr_q;
        rsp_err_d     = rsp_err_q;
`ifdef STORAGE_RD_PARITY_EN
        rsp_parity_d  = rsp_parity_q;
`endif
        case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    if (in_range) begin
                        state_d       = StIssue;
                        mem_rd_en_d   = 1'b1;
                        mem_rd_addr_d = req_addr;
                    end else begin
                        // Error responses skip storage entirely.
                        state_d      = StHold;
                        rsp_valid_d  = 1'b1;
                        rsp_data_d   = '0;
                        rsp_addr_d   = req_addr;
                        rsp_err_d    = 1'b1;
`ifdef STORAGE_RD_PARITY_EN
                        rsp_parity_d = 1'b0;
`endif
                    end
                end
            end
            StIssue: state_d = StCapture;
            StCapture: begin
                state_d      = StHold;
                rsp_valid_d  = 1'b1;
                rsp_data_d   = mem_rd_data;
                rsp_addr_d   = mem_rd_addr_q;
                rsp_err_d    = 1'b0;
`ifdef STORAGE_RD_PARITY_EN
                rsp_parity_d = ^mem_rd_data;
`endif
            end
            StHold: begin
                if (rsp_ready) begin
                    state_d     = StIdle;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
        req_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            req_ready_q   <= 1'b0;
            mem_rd_en_q   <= 1'b0;
            mem_rd_addr_q <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_addr_q    <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            mem_rd_en_q   <= mem_rd_en_d;
            mem_rd_addr_q <= mem_rd_addr_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_addr_q    <= rsp_addr_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

`ifdef STORAGE_RD_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_parity_q <= 1'b0;
        end else begin
            rsp_parity_q <= rsp_parity_d;
        end
    end
    assign rsp_parity = rsp_parity_q;
`else
    assign rsp_parity = 1'b0;
`endif

    assign req_ready   = req_ready_q;
    assign mem_rd_en   = mem_rd_en_q;
    assign mem_rd_addr = mem_rd_addr_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_addr    = rsp_addr_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_storage_read_ctrl.sv
// Directed bench for storage_read_ctrl with a registered storage model; parity expectations
// follow STORAGE_RD_PARITY_EN.
module tb_storage_read_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_addr;
    logic       mem_rd_en;
    logic [3:0] mem_rd_addr;
    logic [7:0] mem_rd_data = 8'h00;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_addr;
    logic       rsp_err;
    logic       rsp_parity;

    int tests    = 0;
    int failures = 0;
    int pulses   = 0;

    logic [7:0] mem [16];

    storage_read_ctrl #(
        .DATA_W(8),
        .ADDR_W(4),
        .DEPTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_addr   (rsp_addr),
        .rsp_err    (rsp_err),
        .rsp_parity (rsp_parity)
    );

    always #5 clk = ~clk;

    // Registered storage: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) begin
            mem_rd_data <= mem[mem_rd_addr];
            pulses <= pulses + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic logic par(input logic [7:0] d);
`ifdef STORAGE_RD_PARITY_EN
        return ^d;
`else
        return 1'b0 & d[0];
`endif
    endfunction

    initial begin
        logic [3:0] addrs [3];
        logic [7:0] exp_data [3];
        int         rsp_cyc [3];
        int         k;
        int         n_rsp;
        int         p0;

        for (int i = 0; i < 16; i++) mem[i] = 8'hEE;
        mem[0] = 8'h07; mem[1] = 8'h5A; mem[2] = 8'h7E; mem[3] = 8'hA5;
        mem[5] = 8'h01; mem[7] = 8'h80;

        rst = 1'b1; req_valid = 1'b1; req_addr = 4'd3; rsp_ready = 1'b0;
        tick();
        tick();
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_rd_addr", mem_rd_addr, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_addr", rsp_addr, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_parity", rsp_parity, 0);
        chk("rst_no_pulse", pulses, 0);

        // Single read of word 3.
        rst = 1'b0; req_valid = 1'b0;
        tick();
        chk("post_rst_ready", req_ready, 1);
        req_valid = 1'b1; req_addr = 4'd3; rsp_ready = 1'b1; p0 = pulses;
        tick();
        req_valid = 1'b0; req_addr = 4'd0;
        chk("s1_rd_en_n1", mem_rd_en, 1);
        chk("s1_rd_addr", mem_rd_addr, 3);
        chk("s1_ready_busy", req_ready, 0);
        chk("s1_valid_n1", rsp_valid, 0);
        tick();
        chk("s1_rd_en_n2", mem_rd_en, 0);
        chk("s1_valid_n2", rsp_valid, 0);
        tick();
        chk("s1_valid_n3", rsp_valid, 1);
        chk("s1_data", rsp_data, 8'hA5);
        chk("s1_addr", rsp_addr, 3);
        chk("s1_err", rsp_err, 0);
        chk("s1_parity", rsp_parity, par(8'hA5));
        chk("s1_ready_hold", req_ready, 0);
        tick();
        chk("s1_valid_clr", rsp_valid, 0);
        chk("s1_ready_back", req_ready, 1);
        chk("s1_data_kept", rsp_data, 8'hA5);
        chk("s1_one_pulse", pulses - p0, 1);

        // Backpressure on word 5.
        rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 4'd5;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("bp_valid", rsp_valid, 1);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_valid_hold", rsp_valid, 1);
            chk("bp_data_hold", rsp_data, 8'h01);
            chk("bp_addr_hold", rsp_addr, 5);
            chk("bp_err_hold", rsp_err, 0);
            chk("bp_parity_hold", rsp_parity, par(8'h01));
            chk("bp_ready_low", req_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_valid_clr", rsp_valid, 0);
        chk("bp_ready_back", req_ready, 1);

        // Out-of-range address 9.
        p0 = pulses;
        req_valid = 1'b1; req_addr = 4'd9;
        tick();
        req_valid = 1'b0;
        chk("oor_valid", rsp_valid, 1);
        chk("oor_err", rsp_err, 1);
        chk("oor_data", rsp_data, 0);
        chk("oor_addr", rsp_addr, 9);
        chk("oor_parity", rsp_parity, 0);
        chk("oor_rd_en", mem_rd_en, 0);
        tick();
        chk("oor_valid_clr", rsp_valid, 0);
        chk("oor_ready_back", req_ready, 1);
        chk("oor_no_pulse", pulses - p0, 0);

        // Back-to-back 0, 7, 2 with requests offered continuously.
        addrs[0] = 4'd0; addrs[1] = 4'd7; addrs[2] = 4'd2;
        exp_data[0] = 8'h07; exp_data[1] = 8'h80; exp_data[2] = 8'h7E;
        k = 0; n_rsp = 0;
        for (int c = 0; c < 20; c++) begin
            if (rsp_valid) begin
                if (n_rsp < 3) begin
                    chk("b2b_data", rsp_data, exp_data[n_rsp]);
                    chk("b2b_addr", rsp_addr, addrs[n_rsp]);
                    chk("b2b_parity", rsp_parity, par(exp_data[n_rsp]));
                    rsp_cyc[n_rsp] = c;
                end
                n_rsp++;
            end
            if (k < 3) begin
                req_valid = 1'b1;
                req_addr  = addrs[k];
                if (req_ready) k++;
            end else begin
                req_valid = 1'b0;
            end
            tick();
        end
        chk("b2b_count", n_rsp, 3);
        if (n_rsp == 3) begin
            chk("b2b_gap1", rsp_cyc[1] - rsp_cyc[0], 4);
            chk("b2b_gap2", rsp_cyc[2] - rsp_cyc[1], 4);
        end

        // Reset asserted in the CAPTURE cycle of a read of word 1.
        req_valid = 1'b1; req_addr = 4'd1;
        tick();
        req_valid = 1'b0;
        chk("mid_rd_en", mem_rd_en, 1);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_valid", rsp_valid, 0);
        chk("mid_rd_en_clr", mem_rd_en, 0);
        chk("mid_rd_addr", mem_rd_addr, 0);
        chk("mid_data", rsp_data, 0);
        chk("mid_addr", rsp_addr, 0);
        chk("mid_ready", req_ready, 0);
        rst = 1'b0;
        tick();
        chk("mid_idle_ready", req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mid_no_valid", rsp_valid, 0);
            chk("mid_no_stale", rsp_data, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
